// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory bus between the load/store unit and memory
interface load_store_unit_if;
  logic        BusReq_o;
  logic        BusWe_o;
  logic [31:0] BusAddr_o;
  logic [31:0] BusWdata_o;
  logic [3:0]  BusBe_o;
  logic        BusGnt_i;
  logic        BusRvalid_i;
  logic [31:0] BusRdata_i;

  modport master (
    output BusReq_o, BusWe_o, BusAddr_o, BusWdata_o, BusBe_o,
    input  BusGnt_i, BusRvalid_i, BusRdata_i
  );

  modport slave (
    input  BusReq_o, BusWe_o, BusAddr_o, BusWdata_o, BusBe_o,
    output BusGnt_i, BusRvalid_i, BusRdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store stage: aligned word bus transactions, stall, load extend
module load_store_unit (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic [2:0]                Funct3_i,
  input  logic [31:0]               Addr_i,
  input  logic [31:0]               WriteData_i,
  output logic                      Stall_o,
  output logic                      Misaligned_o,
  output logic [31:0]               Mem_o,
  load_store_unit_if.master         bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_we;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem;

  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_misalign;
  logic        w_valid;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_be;
  logic [31:0] w_byte_shift;
  logic [31:0] w_half_shift;
  logic [31:0] w_load;

  // Size decode: x00 byte, x01 half, everything else is a word access
  assign w_access   = MemRead_i | MemWrite_i;
  assign w_is_byte  = (Funct3_i[1:0] == 2'b00);
  assign w_is_half  = (Funct3_i[1:0] == 2'b01);
  assign w_misalign = w_access & ((w_is_half & Addr_i[0]) |
                                  (~w_is_byte & ~w_is_half & (|Addr_i[1:0])));
  // Only IDLE samples the instruction; later states own the in-flight one
  assign w_valid    = (r_state == S_IDLE) & w_access & ~w_misalign;

  // Store lane replication and byte enables; loads read the whole word
  always_comb begin
    w_st_wdata = 32'h0;
    w_st_be    = 4'b1111;
    if (MemWrite_i) begin
      if (w_is_byte) begin
        w_st_wdata = {4{WriteData_i[7:0]}};
        w_st_be    = 4'b0001 << Addr_i[1:0];
      end else if (w_is_half) begin
        w_st_wdata = {2{WriteData_i[15:0]}};
        w_st_be    = Addr_i[1] ? 4'b1100 : 4'b0011;
      end else begin
        w_st_wdata = WriteData_i;
      end
    end
  end

  // Load lane extraction and sign/zero extension from the latched size and offset
  assign w_byte_shift = bus.BusRdata_i >> {r_off, 3'b000};
  assign w_half_shift = bus.BusRdata_i >> {r_off[1], 4'b0000};

  always_comb begin
    w_load = bus.BusRdata_i;
    unique case (r_funct3)
      3'b000:  w_load = {{24{w_byte_shift[7]}}, w_byte_shift[7:0]};
      3'b100:  w_load = {24'h0, w_byte_shift[7:0]};
      3'b001:  w_load = {{16{w_half_shift[15]}}, w_half_shift[15:0]};
      3'b101:  w_load = {16'h0, w_half_shift[15:0]};
      default: w_load = bus.BusRdata_i;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM next state: writes skip WAIT_R, rvalid only matters in WAIT_R
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_valid)          w_next = S_REQ;
      S_REQ:    if (bus.BusGnt_i)     w_next = r_we ? S_DONE : S_WAIT_R;
      S_WAIT_R: if (bus.BusRvalid_i)  w_next = S_DONE;
      default:                        w_next = S_IDLE;
    endcase
  end

  // FSM outputs: stall until DONE, fault flag only when a new access is sampled
  always_comb begin
    Stall_o      = w_valid | (r_state == S_REQ) | (r_state == S_WAIT_R);
    Misaligned_o = (r_state == S_IDLE) & w_misalign;
  end

  // Bus registers and load result; a store wins when both flags are set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_we     <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_be     <= 4'h0;
      r_mem    <= 32'h0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_valid) begin
          r_funct3 <= Funct3_i;
          r_off    <= Addr_i[1:0];
          r_we     <= MemWrite_i;
          r_req    <= 1'b1;
          r_addr   <= {Addr_i[31:2], 2'b00};
          r_wdata  <= w_st_wdata;
          r_be     <= w_st_be;
        end
        S_REQ:    if (bus.BusGnt_i)    r_req <= 1'b0;
        S_WAIT_R: if (bus.BusRvalid_i) r_mem <= w_load;
        default: ;
      endcase
    end
  end

  assign bus.BusReq_o   = r_req;
  assign bus.BusWe_o    = r_we;
  assign bus.BusAddr_o  = r_addr;
  assign bus.BusWdata_o = r_wdata;
  assign bus.BusBe_o    = r_be;
  assign Mem_o          = r_mem;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Addr_i;
  logic [31:0] WriteData_i;
  logic        Stall_o;
  logic        Misaligned_o;
  logic [31:0] Mem_o;

  load_store_unit_if bus_if ();

  load_store_unit dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .Funct3_i     (Funct3_i),
    .Addr_i       (Addr_i),
    .WriteData_i  (WriteData_i),
    .Stall_o      (Stall_o),
    .Misaligned_o (Misaligned_o),
    .Mem_o        (Mem_o),
    .bus          (bus_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    logic [31:0] mem;
    int          stalls;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Bus monitor: every cycle a request is up it must match the head transaction
  initial forever begin
    @(negedge clk_i);
    if (bus_if.BusReq_o === 1'b1) begin
      if (bus_q.size() == 0) begin
        check("spurious_req", 32'(bus_if.BusReq_o), 32'h0);
      end else begin
        check("bus_addr",  bus_if.BusAddr_o,        bus_q[0].addr);
        check("bus_we",    32'(bus_if.BusWe_o),     32'(bus_q[0].we));
        check("bus_wdata", bus_if.BusWdata_o,       bus_q[0].wdata);
        check("bus_be",    32'(bus_if.BusBe_o),     32'(bus_q[0].be));
        if (bus_if.BusGnt_i) void'(bus_q.pop_front());
      end
    end
  end

  // Retire monitor: first non-stalled cycle after a stall run is DONE
  initial forever begin
    @(negedge clk_i);
    if (!mon_en) begin
      stall_cnt = 0;
    end else if (Stall_o) begin
      stall_cnt++;
    end else if (stall_cnt > 0) begin
      if (res_q.size() == 0) begin
        check("spurious_retire", 32'(stall_cnt), 32'h0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("mem_o",  Mem_o,            r.mem);
        check("stalls", 32'(stall_cnt),   32'(r.stalls));
      end
      stall_cnt = 0;
    end
  end

  // Entered and left at posedge+1 with the FSM in IDLE
  task automatic do_access(
    input bit rd, input bit wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input int gd, input int rdl, input logic [31:0] rdata, input bit stray,
    input logic [31:0] exp_mem, input logic [31:0] exp_baddr,
    input logic [31:0] exp_bwdata, input logic [3:0] exp_be);
    bus_t b;
    res_t r;
    bit   is_rd;
    is_rd = rd & ~wr;
    b = '{exp_baddr, wr, exp_bwdata, exp_be};
    bus_q.push_back(b);
    r = '{exp_mem, 2 + gd + (is_rd ? rdl + 1 : 0)};
    res_q.push_back(r);
    MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3; Addr_i = addr; WriteData_i = wd;
    @(posedge clk_i); #1;
    bus_if.BusRvalid_i = stray;
    bus_if.BusRdata_i  = 32'h5A5A_5A5A;
    repeat (gd) begin @(posedge clk_i); #1; end
    bus_if.BusGnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_if.BusGnt_i    = 1'b0;
    bus_if.BusRvalid_i = 1'b0;
    if (is_rd) begin
      repeat (rdl) begin @(posedge clk_i); #1; end
      bus_if.BusRvalid_i = 1'b1;
      bus_if.BusRdata_i  = rdata;
      @(posedge clk_i); #1;
      bus_if.BusRvalid_i = 1'b0;
      bus_if.BusRdata_i  = 32'h5A5A_5A5A;
    end
    @(posedge clk_i); #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  task automatic misaligned(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] exp_mem);
    MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3; Addr_i = addr; WriteData_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("misaligned_flag",  32'(Misaligned_o), 32'h1);
    check("misaligned_stall", 32'(Stall_o),      32'h0);
    check("misaligned_mem",   Mem_o,             exp_mem);
    @(posedge clk_i); #1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    @(negedge clk_i);
    check("misaligned_clear", 32'(Misaligned_o), 32'h0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int gd;
    int rdl;
    rst_ni = 1'b0;
    MemRead_i = 1'b0; MemWrite_i = 1'b0; Funct3_i = 3'b000; Addr_i = 32'h0; WriteData_i = 32'h0;
    bus_if.BusGnt_i = 1'b0; bus_if.BusRvalid_i = 1'b0; bus_if.BusRdata_i = 32'h5A5A_5A5A;
    repeat (2) @(negedge clk_i);
    check("rst_stall",  32'(Stall_o),             32'h0);
    check("rst_mis",    32'(Misaligned_o),        32'h0);
    check("rst_mem",    Mem_o,                    32'h0);
    check("rst_req",    32'(bus_if.BusReq_o),     32'h0);
    check("rst_we",     32'(bus_if.BusWe_o),      32'h0);
    check("rst_addr",   bus_if.BusAddr_o,         32'h0);
    check("rst_wdata",  bus_if.BusWdata_o,        32'h0);
    check("rst_be",     32'(bus_if.BusBe_o),      32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // rd wr f3 addr wdata gd rdl rdata stray | mem baddr bwdata be
    do_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 0,
              32'hFFFF_FF80, 32'h0000_1000, 32'h0, 4'b1111);
    do_access(1, 0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000, 0,
              32'h0000_BEEF, 32'h0000_2000, 32'h0, 4'b1111);
    do_access(0, 1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 3, 0, 32'h0, 0,
              32'h0000_BEEF, 32'h0000_0010, 32'hABAB_ABAB, 4'b0010);
    do_access(1, 0, 3'b001, 32'h0000_0102, 32'h0, 1, 2, 32'h8001_0000, 0,
              32'hFFFF_8001, 32'h0000_0100, 32'h0, 4'b1111);
    do_access(1, 1, 3'b001, 32'h0000_0006, 32'h0000_CAFE, 0, 0, 32'h0, 1,
              32'hFFFF_8001, 32'h0000_0004, 32'hCAFE_CAFE, 4'b1100);
    do_access(1, 0, 3'b100, 32'h0000_0005, 32'h0, 0, 1, 32'h0000_9A00, 0,
              32'h0000_009A, 32'h0000_0004, 32'h0, 4'b1111);

    misaligned(1, 0, 3'b010, 32'h0000_0006, 32'h0000_009A);
    misaligned(0, 1, 3'b001, 32'h0000_0001, 32'h0000_009A);

    gd = $urandom_range(0, 3);
    do_access(0, 1, 3'b010, 32'h0000_0040, 32'h1234_5678, gd, 0, 32'h0, 1,
              32'h0000_009A, 32'h0000_0040, 32'h1234_5678, 4'b1111);
    gd  = $urandom_range(0, 3);
    rdl = $urandom_range(0, 3);
    do_access(1, 0, 3'b010, 32'h0000_0040, 32'h0, gd, rdl, 32'h1234_5678, 0,
              32'h1234_5678, 32'h0000_0040, 32'h0, 4'b1111);

    // Reset while a read waits for its data; the late rvalid must be dropped
    mon_en = 1'b0;
    bus_q.push_back('{32'h0000_0080, 1'b0, 32'h0, 4'b1111});
    MemRead_i = 1'b1; Funct3_i = 3'b010; Addr_i = 32'h0000_0080;
    @(posedge clk_i); #1;
    bus_if.BusGnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_if.BusGnt_i = 1'b0;
    rst_ni = 1'b0;
    MemRead_i = 1'b0;
    #1;
    check("mid_rst_req",   32'(bus_if.BusReq_o),  32'h0);
    check("mid_rst_we",    32'(bus_if.BusWe_o),   32'h0);
    check("mid_rst_addr",  bus_if.BusAddr_o,      32'h0);
    check("mid_rst_wdata", bus_if.BusWdata_o,     32'h0);
    check("mid_rst_be",    32'(bus_if.BusBe_o),   32'h0);
    check("mid_rst_mem",   Mem_o,                 32'h0);
    check("mid_rst_stall", 32'(Stall_o),          32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    bus_if.BusRvalid_i = 1'b1;
    bus_if.BusRdata_i  = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    bus_if.BusRvalid_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("post_rst_mem",   Mem_o,            32'h0);
      check("post_rst_stall", 32'(Stall_o),     32'h0);
    end

    repeat (3) @(posedge clk_i);
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("res_q_empty", 32'(res_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the CPU: it sits between the ALU address and the memory bus, and it feeds the `Mem_i` input of the result selector. It turns load/store control into word-aligned bus transactions with byte enables. It stalls the core for the whole transaction, then returns loaded data zero- or sign-extended in a result register that holds until the next load completes. It detects misaligned accesses and never issues them to the bus.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk_i` in 1: core clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `MemRead_i` in 1: current instruction is a load.
- `MemWrite_i` in 1: current instruction is a store.
- `Funct3_i` in 3: access size. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; 011/110/111 are treated as word.
- `Addr_i` in 32: byte address from the ALU.
- `WriteData_i` in 32: store data (rs2), with the low bits carrying the byte or half.
- `Stall_o` out 1: freezes PC and pipeline inputs while high.
- `Misaligned_o` out 1: access-fault flag, combinational.
- `Mem_o` out 32: load result to the result selector.
- `BusReq_o` out 1: request valid.
- `BusWe_o` out 1: 1 for write.
- `BusAddr_o` out 32: word address, with [1:0] always 00.
- `BusWdata_o` out 32: lane-replicated store data.
- `BusBe_o` out 4: byte enables.
- `BusGnt_i` in 1: bus accepts the request this cycle.
- `BusRvalid_i` in 1: read data valid.
- `BusRdata_i` in 32: read data.

## Operation
- FSM states are IDLE, REQ, WAIT_R and DONE. Reset state is IDLE.
- **IDLE**
  - A valid access is `MemRead_i | MemWrite_i` with the access aligned.
  - On a valid access, latch `Funct3_i`, `Addr_i[1:0]` and the read/write flag, drive the bus registers, and go to REQ.
  - If both `MemRead_i` and `MemWrite_i` are high, the store wins.
- **Alignment**
  - Half accesses with `Addr_i[0]` = 1 are misaligned.
  - Word accesses with `Addr_i[1:0]` ≠ 00 are misaligned.
  - A misaligned access:
    - raises `Misaligned_o` that cycle;
    - issues no request and does not stall;
    - leaves `Mem_o` unchanged;
    - keeps the FSM in IDLE.
- **REQ**
  - `BusReq_o` is held high with stable address, data and byte enables until `BusGnt_i` = 1.
  - On grant, a write goes to DONE and a read goes to WAIT_R.
  - `BusReq_o` clears at that edge.
- **WAIT_R**
  - Wait for `BusRvalid_i`.
  - On rvalid, extract and extend the data into `Mem_o`, then go to DONE.
  - `BusRvalid_i` is honoured only in WAIT_R and ignored in every other state.
- **DONE**
  - `Stall_o` is low for exactly one cycle so the instruction retires.
  - Request inputs are ignored in DONE because they belong to the retiring instruction.
  - Return to IDLE.
- `Stall_o` = (IDLE & valid access) | REQ | WAIT_R.
- **Store lanes**
  - `BusAddr_o` = {Addr[31:2], 00}.
  - SB: wdata = {4{WriteData[7:0]}}, be = 0001 << Addr[1:0].
  - SH: wdata = {2{WriteData[15:0]}}, be = 0011 (Addr[1] = 0) or 1100.
  - SW: wdata = WriteData, be = 1111.
  - Loads drive be = 1111 and wdata = 0.
- **Load extract**
  - Byte = Rdata[8·Addr[1:0] +: 8]; half = Rdata[16·Addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the data through.
- Stores never modify `Mem_o`.
- **Reset**, at any time including mid-transaction:
  - FSM → IDLE;
  - `BusReq_o`, `BusWe_o`, `BusAddr_o`, `BusWdata_o`, `BusBe_o` and `Mem_o` = 0;
  - `Stall_o` and `Misaligned_o` follow their combinational terms.
- A transaction in flight at reset is abandoned; a late `BusRvalid_i` is ignored.

## Timing
- Bus outputs are registered and update on the IDLE→REQ edge. They are stable throughout REQ.
- **Zero-wait load**, 3 stall cycles:
  - c0 IDLE, stall;
  - c1 REQ, grant;
  - c2 WAIT_R, rvalid;
  - c3 DONE, `Mem_o` valid, stall low.
- **Zero-wait store**, 2 stall cycles:
  - c0 IDLE, stall;
  - c1 REQ, grant;
  - c2 DONE.
- Each cycle of grant delay adds one cycle in REQ; each cycle of rvalid delay adds one cycle in WAIT_R.
- Bus contract: rvalid comes at least one cycle after grant, and only one outstanding read is allowed.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE.
- Minimum spacing between bus requests is therefore 3 cycles for stores and 4 for loads.

## Test plan
- **LB, sign-extended byte**
  - Stimulus: Funct3 = 000, Addr = 0x1003, rdata 0x80FF_1234, zero-wait bus.
  - Required: BusAddr 0x1000, be 1111, `Mem_o` = 0xFFFF_FF80 in DONE, `Stall_o` high for exactly 3 cycles.
- **LHU, zero-extended half**
  - Stimulus: Funct3 = 101, Addr = 0x2002, rdata 0xBEEF_0000.
  - Required: `Mem_o` = 0x0000_BEEF.
- **SB with grant delay**
  - Stimulus: Addr = 0x0011, WriteData = 0xAB, grant held low for 3 cycles.
  - Required: req/addr/wdata 0xABAB_ABAB/be 0010 stable throughout, stall for 5 cycles, `Mem_o` unchanged.
- **Misaligned accesses**
  - Stimulus: LW at 0x0006; SH at 0x0001.
  - Required: `Misaligned_o` = 1 for one cycle, `BusReq_o` never rises, `Stall_o` = 0.
- **Reset mid-transaction**
  - Stimulus: assert `rst_ni` low while in WAIT_R, then drive rvalid after release.
  - Required: all bus outputs 0 immediately, FSM IDLE, `Mem_o` = 0 and stays 0.
- **Back-to-back traffic with random delays**
  - Stimulus: SW 0x1234_5678 to 0x40, then LW from 0x40.
  - Required: exactly one request per instruction, `Mem_o` = 0x1234_5678, no spurious rvalid capture.
